div47_seq_radix8: RTL
=====================

Name: div47_seq_radix8

Overview:
- Sequential constant divider: divides an unsigned 36-bit dividend by the fixed constant 47.
- Processes the dividend as 12 radix-8 digits, most-significant first, one digit per clock.
- Each step maps a 9-bit word {partial remainder[5:0], dividend digit[2:0]} to {quotient digit[2:0], new remainder[5:0]}. This is the same digit-step function the combinational quotient/remainder table implements.
- Sits upstream of result consumers on a valid/ready interface. Replaces a 12-deep unrolled chain where area matters more than throughput.

Parameters:
- WIDTH, 36, dividend width in bits; must be a multiple of 3.
- DIGITS, 12, number of radix-8 steps; equals WIDTH/3.
- CW, 4, width of the digit counter; must satisfy 2^CW > DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  dividend present.
- in_ready  out  1  block can accept a dividend.
- in_data  in  WIDTH  unsigned dividend.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_quot  out  WIDTH  quotient = floor(in_data/47); bits [35:31] are always 0.
- out_rem  out  6  remainder = in_data mod 47, range 0..46.

Behaviour:
- One clock domain. Reset is asynchronous and active-high; all state is cleared asynchronously on rst=1.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - out_quot=0, out_rem=0.
  - internal remainder=0, digit counter=0, dividend shift register=0.
- Digit step, purely combinational inside the block:
  - t = rem*8 + d.
  - q = floor(t/47), r = t - 47*q.
  - Because rem ≤ 46, t ≤ 375, so q ≤ 7 (fits 3 bits) and r ≤ 46 (fits 6 bits).
  - Implement as compare/subtract against 47*k for k=1..7, or as a 9-in/9-out table. No divider operator.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1.
    - On in_valid & in_ready: load shift register ← in_data, rem ← 0, quotient register ← 0, counter ← 0; go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Each cycle take d = shift[WIDTH-1:WIDTH-3].
    - Update: rem ← r; quot ← {quot[WIDTH-4:0], q}; shift ← shift << 3; counter ← counter+1.
    - When the counter equals DIGITS-1 at a clock edge, that edge performs the last step and moves to DONE.
  - DONE: out_valid=1; out_quot and out_rem hold stable while out_valid=1 & out_ready=0.
    - On out_ready=1: go to IDLE.
- Latency: acceptance edge E. out_valid rises after edge E+12 (12 RUN cycles). Minimum per-operation period is 14 cycles (IDLE, 12×RUN, DONE).
- in_ready is low throughout RUN and DONE, so a new dividend is never accepted in the same cycle a result is consumed.
- in_data is sampled only at acceptance; changes on it during RUN/DONE have no effect.
- in_valid during RUN/DONE is ignored; the upstream must hold it until in_ready.
- out_valid=0 in IDLE and RUN. out_quot/out_rem keep the last result until the next acceptance, but are meaningful only while out_valid=1.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE with reset values. The partial result is discarded; no out_valid pulse.
- Counter wrap: the counter never exceeds DIGITS-1 and is cleared on acceptance.

Test Plan:
- Reset then in_data=0 → out_valid after 12 RUN cycles, out_quot=0, out_rem=0.
- in_data=47 → out_quot=1, out_rem=0. in_data=46 → out_quot=0, out_rem=46.
- in_data=1000 → out_quot=21, out_rem=13. in_data=2^36-1 (68719476735) → out_quot=1462116526, out_rem=13.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, outputs stable, in_ready stays 0. Then out_ready=1 → IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with 3 dividends → each result correct, acceptances spaced 14 cycles apart, no result dropped or duplicated.
- Assert rst at RUN cycle 6 → out_valid=0 and in_ready=1 immediately. Next dividend 94 → out_quot=2, out_rem=0.
- Random: 10k uniformly random 36-bit dividends vs. software floor/mod by 47 → all match, and out_rem < 47 always.

Source files
------------

// File: rtl/div47_seq_radix8.sv
// div47_seq_radix8: sequential divide-by-47, one radix-8 dividend digit per clock, valid/ready handshake
module div47_seq_radix8 #(
    parameter int WIDTH  = 36,
    parameter int DIGITS = 12,
    parameter int CW     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [5:0]       out_rem
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [5:0]       rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [8:0]       t;
    logic [2:0]       q;
    logic [5:0]       r;
    // Digit step: quotient digit is how many multiples of 47 fit in {rem, digit}
    always_comb begin
        t = {rem_q, shift_q[WIDTH-1 -: 3]};
        q = '0;
        for (int k = 1; k < 8; k++)
            if (t >= 9'(47 * k)) q = 3'(k);
        r = 6'(t - 9'(47 * int'(q)));
    end
    // Next-state: accept in IDLE, shift one digit per RUN cycle, hold result in DONE
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                shift_d = in_data;
                quot_d  = '0;
                rem_d   = '0;
                cnt_d   = '0;
            end
            RUN: begin
                shift_d = shift_q << 3;
                quot_d  = {quot_q[WIDTH-4:0], q};
                rem_d   = r;
                state_d = (cnt_q == CW'(DIGITS - 1)) ? DONE : RUN;
                cnt_d   = (cnt_q == CW'(DIGITS - 1)) ? cnt_q : cnt_q + 1'b1;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_quot  = quot_q;
    assign out_rem   = rem_q;
endmodule
